// File: rtl/fp_div32.sv
// fp_div32: iterative IEEE-754 single-precision divider, one quotient bit per
// clock by restoring mantissa division. Special operands (NaN, Inf, zero,
// flushed denormals) resolve in the accept cycle. Results are held in DONE
// until the consumer accepts them. The reservation-station tag rides along.
//
// Optional feature macro FPDIV_RNE_EN: when defined, two extra quotient bits
// are developed and PACK rounds to nearest-even. When undefined, the quotient
// is truncated (round toward zero).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE. out_valid is high only in DONE and stays
// high, with stable data, until out_ready is seen.
module fp_div32 #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

`ifdef FPDIV_RNE_EN
  localparam int NQ = 26;
`else
  localparam int NQ = 24;
`endif

  typedef enum logic [1:0] {IDLE, DIV, PACK, DONE} state_t;
  state_t state, state_nxt;

  // Datapath registers. q drops the leading quotient bit, which is always 1.
  logic [25:0]   rem;
  logic [23:0]   mb;
  logic [NQ-2:0] q;
  logic [4:0]    cnt;
  logic [9:0]    expo;
  logic          sign;

  // Operand fields and classification, taken straight from the input ports.
  logic [7:0]  ea, eb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
  logic        sign_ab, adj;
  logic [23:0] ma_in, mb_in;
  logic [9:0]  expo_init;
  logic [31:0] spec_data;
  logic [3:0]  spec_flags;

  assign ea      = in_a[30:23];
  assign eb      = in_b[30:23];
  assign a_nan   = (ea == 8'hFF) && (in_a[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (in_b[22:0] != 23'd0);
  assign a_inf   = (ea == 8'hFF) && (in_a[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (in_b[22:0] == 23'd0);
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  assign sign_ab = in_a[31] ^ in_b[31];
  assign ma_in   = {1'b1, in_a[22:0]};
  assign mb_in   = {1'b1, in_b[22:0]};
  assign adj     = (ma_in < mb_in);
  // Two's-complement 10-bit arithmetic; interpreted as signed in PACK.
  assign expo_init = {2'b00, ea} - {2'b00, eb} + 10'd127 - {9'd0, adj};

  // Result of a special-operand division, priority-ordered.
  always_comb begin
    spec_data  = {sign_ab, 31'd0};
    spec_flags = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_data  = 32'h7FC0_0000;
      spec_flags = 4'b1000;
    end else if (b_zero) begin
      spec_data  = {sign_ab, 8'hFF, 23'd0};
      spec_flags = 4'b0100;
    end else if (a_inf) begin
      spec_data  = {sign_ab, 8'hFF, 23'd0};
    end
  end

  // Restoring step: the sign bit of the trial difference picks the quotient bit.
  logic [25:0] trial;
  assign trial = rem - {2'b00, mb};

  // Final rounding (optional) and range check of the packed result.
  logic [22:0] frac;
  logic [9:0]  expo_f;
  logic [31:0] pack_data;
  logic [3:0]  pack_flags;
`ifdef FPDIV_RNE_EN
  logic        rnd_up;
  logic [23:0] frac_sum;
  assign rnd_up   = q[1] & (q[0] | (rem != 26'd0) | q[2]);
  assign frac_sum = {1'b0, q[24:2]} + {23'd0, rnd_up};
  assign frac     = frac_sum[22:0];
  assign expo_f   = expo + {9'd0, frac_sum[23]};
`else
  assign frac     = q[22:0];
  assign expo_f   = expo;
`endif

  // Overflow saturates to Inf, underflow flushes to zero.
  always_comb begin
    pack_data  = {sign, expo_f[7:0], frac};
    pack_flags = 4'b0000;
    if ($signed(expo_f) >= 10'sd255) begin
      pack_data  = {sign, 8'hFF, 23'd0};
      pack_flags = 4'b0010;
    end else if ($signed(expo_f) <= 10'sd0) begin
      pack_data  = {sign, 31'd0};
      pack_flags = 4'b0001;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = special ? DONE : DIV;
      DIV:  if (cnt == 5'd0) state_nxt = PACK;
      PACK: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Datapath: latch operands, iterate the division, pack the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= 32'd0;
      out_tag   <= '0;
      out_flags <= 4'd0;
      rem       <= 26'd0;
      mb        <= 24'd0;
      q         <= '0;
      cnt       <= 5'd0;
      expo      <= 10'd0;
      sign      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          out_tag <= in_tag;
          sign    <= sign_ab;
          if (special) begin
            out_data  <= spec_data;
            out_flags <= spec_flags;
          end else begin
            rem  <= adj ? {1'b0, ma_in, 1'b0} : {2'b00, ma_in};
            mb   <= mb_in;
            expo <= expo_init;
            cnt  <= 5'(NQ - 1);
            q    <= '0;
          end
        end
        DIV: begin
          q   <= {q[NQ-3:0], ~trial[25]};
          rem <= trial[25] ? (rem << 1) : (trial << 1);
          cnt <= cnt - 5'd1;
        end
        PACK: begin
          out_data  <= pack_data;
          out_flags <= pack_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div32.sv
// tb_fp_div32: directed vectors for fp_div32. A driver issues operations and
// pushes the expected {data, flags, tag} into exp_q; a monitor pops and
// compares whenever a result is handed off. Latency, backpressure and reset
// behaviour are checked inline by the driver.
module tb_fp_div32;

`ifdef FPDIV_RNE_EN
  localparam int NL = 28;
  localparam logic [31:0] Q13 = 32'h3EAA_AAAB;
`else
  localparam int NL = 26;
  localparam logic [31:0] Q13 = 32'h3EAA_AAAA;
`endif

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_data;
  logic [3:0]  in_tag, out_tag, out_flags;

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];

  fp_div32 #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_flags(out_flags)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: compare each handed-off result with the head of the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h with empty queue", out_data);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("data",  out_data, e[39:8]);
        chk("flags", {28'd0, out_flags}, {28'd0, e[7:4]});
        chk("tag",   {28'd0, out_tag},   {28'd0, e[3:0]});
      end
    end
  end

  // Driver: wait for in_ready, present one operation for one accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       input logic [31:0] ed, input logic [3:0] ef, input bit push);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    if (push) exp_q.push_back({ed, ef, tag});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges (accepting edge = 1) until out_valid appears.
  task automatic wait_valid(input int elat);
    int lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
  endtask

  typedef struct {
    logic [31:0] a, b, q;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'h0, NL};
    vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, Q13,           4'h0, NL};
    vecs[2]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'h4, 1};
    vecs[3]  = '{32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 4'h8, 1};
    vecs[4]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'h2, NL};
    vecs[5]  = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'h1, NL};
    vecs[6]  = '{32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 4'h0, 1};
    vecs[7]  = '{32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 4'h0, NL};
    vecs[8]  = '{32'h40C0_0000, 32'hFF80_0000, 32'h8000_0000, 4'h0, 1};
    vecs[9]  = '{32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 4'h0, 1};
    vecs[10] = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'h8, 1};
    vecs[11] = '{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'h8, 1};
    vecs[12] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'h0, NL};
    vecs[13] = '{32'h4040_0000, 32'h3FC0_0000, 32'h4000_0000, 4'h0, NL};
    vecs[14] = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'h0, 1};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_tag",   32'(out_tag),   32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    rst = 1'b0;

    // Directed vectors with a free-running consumer.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, 4'(i), vecs[i].q, vecs[i].f, 1'b1);
      wait_valid(vecs[i].lat);
    end

    // Backpressure: consumer stalls five cycles while the result is held.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(32'h40C0_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, 4'h0, 1'b1);
    wait_valid(NL);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_data",      out_data,       32'h4040_0000);
      chk("bp_tag",       32'(out_tag),   32'd5);
      chk("bp_flags",     32'(out_flags), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    issue(32'h3F80_0000, 32'h4040_0000, 4'd9, Q13, 4'h0, 1'b1);
    wait_valid(NL);

    // Reset during the 10th DIV cycle discards the operation.
    issue(32'h40C0_0000, 32'h4000_0000, 4'd3, 32'h0, 4'h0, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("div_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_out_data",  out_data,       32'd0);
    chk("mid_rst_out_tag",   32'(out_tag),   32'd0);
    chk("mid_rst_out_flags", 32'(out_flags), 32'd0);
    rst = 1'b0;
    issue(32'h40C0_0000, 32'h4000_0000, 4'd7, 32'h4040_0000, 4'h0, 1'b1);
    wait_valid(NL);

    // Drain: every expected result must have been seen.
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
